// File: rtl/dmem_responder.sv
// Data-memory responder: RV32I byte/half/word loads and stores over a req/ack
// handshake with a fixed number of wait states and access-fault reporting.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AB    = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [AB-1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic              in_idle, accept, do_access;
    logic              misaligned, out_of_range, illegal, err_in;
    logic              acc_we, acc_err;
    logic [2:0]        acc_f3;
    logic [AB-1:0]     acc_addr;
    logic [31:0]       acc_wdata;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]       rd_word, load_val, st_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [3:0]        st_be;

    always_comb begin
        misaligned   = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                       (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        out_of_range = (addr_i >> AB) != '0;
        illegal      = we_i ? (funct3_i[2] || funct3_i[1:0] == 2'b11)
                            : (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11);
        err_in       = misaligned || out_of_range || illegal;
    end

    assign in_idle   = (state == IDLE);
    assign accept    = in_idle && req_i;
    assign do_access = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);

    // Zero-wait accesses happen on the accepting edge, so they use the live inputs.
    always_comb begin
        acc_we    = in_idle ? we_i               : we_q;
        acc_f3    = in_idle ? funct3_i           : funct3_q;
        acc_addr  = in_idle ? addr_i[AB-1:0]     : addr_q;
        acc_wdata = in_idle ? wdata_i            : wdata_q;
        acc_err   = in_idle ? err_in             : err_q;
    end

    assign word_idx = acc_addr[AB-1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = 8'(rd_word >> {acc_addr[1:0], 3'b000});
    assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = '0;
        st_be    = '0;
        st_data  = acc_wdata;
        case (acc_f3)
            3'b000: load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001: load_val = {{16{rd_half[15]}}, rd_half};
            3'b010: load_val = rd_word;
            3'b100: load_val = {24'h0, rd_byte};
            3'b101: load_val = {16'h0, rd_half};
            default: load_val = '0;
        endcase
        case (acc_f3)
            3'b000: begin
                st_be   = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            3'b010: st_be = 4'b1111;
            default: st_be = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_access && acc_we && !acc_err && !reset_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt      <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= we_i;
                funct3_q <= funct3_i;
                addr_q   <= addr_i[AB-1:0];
                wdata_q  <= wdata_i;
                err_q    <= err_in;
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_o <= (acc_we || acc_err) ? '0 : load_val;
                err_o   <= acc_err;
            end else if (state == ACK) begin
                err_o   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = (WAIT_CYCLES == 0) ? ACK : WAIT;
            WAIT:    if (cnt == 4'd1) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        ack_o  = (state == ACK);
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves the memory stage's load/store requests over a req/ack handshake, with a programmable wait-state latency. It implements the RV32I access sizes (byte/half/word), sign/zero extension, and error detection. While an access is in flight it drives `busy_o`, which the pipeline uses to stall the memory stage.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; array is 2^ADDR_WIDTH 32-bit words (4 KB at default).
- `WAIT_CYCLES`, default 2: wait states per access; legal range 0..15.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `req_i`  in  1  request valid; sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  RV32I width/sign code.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-justified.
- `busy_o`  out  1  state != IDLE.
- `ack_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load result; valid while `ack_o` is high.
- `err_o`  out  1  pulses with `ack_o` on a faulted access.

## Operation
- FSM states:
  - IDLE: `req_i`=1 captures `we_i`, `funct3_i`, `addr_i`, `wdata_i` and the error flag. Goes to WAIT with cnt=WAIT_CYCLES, or performs the access directly and goes to ACK when WAIT_CYCLES=0.
  - WAIT: at each edge, if cnt==1, perform the access and go to ACK; otherwise cnt--.
  - ACK: `ack_o`=1 for this cycle. Next edge returns to IDLE unconditionally; `req_i` is ignored here.
- Access edge behaviour:
  - Store: writes the array with byte enables.
  - Load: registers the formatted read into `rdata_o`.
  - Both: sets the `err_o` register.
- Captured request fields are held in registers, so the inputs may change after the accepting edge.
- Load formatting by funct3, with lane selected by `addr[1:0]`:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the half at `addr[1]`.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the half at `addr[1]`.
- Store by funct3:
  - 000 SB: `wdata[7:0]` into byte lane `addr[1:0]`.
  - 001 SH: `wdata[15:0]` into half `addr[1]`.
  - 010 SW: full word.
  - Lanes not selected keep their contents.
- Error conditions, evaluated at accept:
  - Misaligned: half access with `addr[0]`=1, or word access with `addr[1:0]`!=0.
  - Out of range: `addr[31:ADDR_WIDTH+2]` != 0.
  - Illegal funct3: loads 011/110/111; stores any code other than 000/001/010.
- On error: no array write, `rdata_o`=0, `err_o`=1 with `ack_o`, same latency as a good access.
- Store completion sets `rdata_o`=0. `rdata_o` holds its value until the next access edge.
- Array contents are not cleared by reset; they are undefined at power-up.

## Timing
- Reset values: state IDLE, cnt 0, `busy_o`=0, `ack_o`=0, `err_o`=0, `rdata_o`=0.
- Latency: with the accepting edge as edge 0, `ack_o` is high in the cycle after edge WAIT_CYCLES. That is WAIT_CYCLES+1 cycles counting the request cycle.
- `busy_o` rises after edge 0 and falls after the ACK-exit edge. `busy_o` is low only in IDLE.
- Handshake: the requester drops `req_i` in the `ack_o` cycle unless it is issuing a new request. `req_i` still high after ACK is accepted as a new request.
- Minimum request-to-request period: WAIT_CYCLES+2 cycles.
- Reset mid-operation: returns to IDLE immediately. A pending store whose access edge has not occurred is dropped, and no `ack_o` is produced.
- `req_i` arriving while in WAIT or ACK is neither queued nor accepted.

## Test plan
- Reset, WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> `ack_o` high exactly 3 cycles after each request cycle, `rdata_o`=0xDEADBEEF, `err_o`=0, `busy_o` high for 3 cycles.
- SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- SH 0x12 data 0x1234, then LHU 0x12 -> 0x00001234; LH 0x10 -> 0xFFFFBEEF.
- LW 0x11, SH 0x13, and LW 0x1000 (out of range at ADDR_WIDTH=10) -> each gives `ack_o` with `err_o`=1 and `rdata_o`=0; follow-up LW 0x10 shows memory unchanged.
- Assert `reset_i` in the first WAIT cycle of SW 0x20 data 0x55 -> outputs zero immediately, no ack; LW 0x20 returns the pre-reset value.
- WAIT_CYCLES=0 build: back-to-back loads with `req_i` held high -> `ack_o` every 2nd cycle; `req_i` held high through ACK produces no extra acknowledge.
